nmix_core: RTL and testbench



---
 rtl/nmix_core.sv | 67 ++++++
 tb/tb_nmix_core.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/nmix_core.sv
// Iterative 32-bit MixBits-style mixer: 32 rounds of z = (z >> 1) + 2*z + key.
// Optional macro NMIX_UNROLL2_EN chains two rounds per clock (16 cycles to done).
module nmix_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] X,
    input  logic [31:0] R,
    output logic [31:0] Y,
    output logic        done
);

    localparam logic [5:0] ROUNDS = 6'd32;

`ifdef NMIX_UNROLL2_EN
    localparam logic [5:0] STEP = 6'd2;
`else
    localparam logic [5:0] STEP = 6'd1;
`endif

    logic [31:0] r_z;
    logic [31:0] r_key;
    logic [5:0]  r_cnt;
    logic [31:0] r_y;
    logic        r_done;

    logic [31:0] w_z1;
    logic [31:0] w_z_next;
    logic [5:0]  w_cnt_next;

    function automatic logic [31:0] mix_round(input logic [31:0] z, input logic [31:0] k);
        return (z >> 1) + (z << 1) + k;
    endfunction

    assign w_z1 = mix_round(r_z, r_key);

`ifdef NMIX_UNROLL2_EN
    logic [31:0] w_z2;
    assign w_z2     = mix_round(w_z1, r_key);
    assign w_z_next = w_z2;
`else
    assign w_z_next = w_z1;
`endif

    assign w_cnt_next = r_cnt + STEP;

    // cnt < 32 is RUN, cnt == 32 is DONE; reset reloads from any state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_z    <= X;
            r_key  <= R;
            r_cnt  <= 6'd0;
            r_y    <= 32'd0;
            r_done <= 1'b0;
        end else if (r_cnt < ROUNDS) begin
            r_z   <= w_z_next;
            r_cnt <= w_cnt_next;
            if (w_cnt_next == ROUNDS) begin
                r_y    <= w_z_next;
                r_done <= 1'b1;
            end
        end
    end

    assign Y    = r_y;
    assign done = r_done;

endmodule

// File: tb/tb_nmix_core.sv
// Directed bench for nmix_core: latency, result, hold, reset-abort and reset-in-DONE.
module tb_nmix_core;

`ifdef NMIX_UNROLL2_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 32;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] X;
    logic [31:0] R;
    logic [31:0] Y;
    logic        done;

    int checks = 0;
    int errors = 0;

    nmix_core dut (
        .clk  (clk),
        .reset(reset),
        .X    (X),
        .R    (R),
        .Y    (Y),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mix(input logic [31:0] x, input logic [31:0] r);
        logic [31:0] z;
        z = x;
        for (int i = 0; i < 32; i++) z = (z >> 1) + (z << 1) + r;
        return z;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs LAT non-reset edges; done must stay low until the last one.
    task automatic run_expect(input string tag, input logic [31:0] exp_y);
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (i < LAT) begin
                check({tag, "_done_early"}, {31'd0, done}, 32'd0);
            end else begin
                check({tag, "_done"}, {31'd0, done}, 32'd1);
                check({tag, "_y"}, Y, exp_y);
            end
        end
    endtask

    logic [31:0] exp_a;
    logic [31:0] exp_b;

    initial begin
        reset = 1'b1;
        X = 32'd0;
        R = 32'd0;
        exp_a = ref_mix(32'h8DDB7DD3, 32'h050D6C7F);
        exp_b = ref_mix(32'h12345678, 32'h9ABCDEF0);

        // reset held 5 cycles: no rounds, outputs cleared
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_rst_y", Y, 32'd0);
            check("hold_rst_done", {31'd0, done}, 32'd0);
        end
        reset = 1'b0;
        run_expect("zero", 32'd0);

        // nonzero operands, result holds afterwards
        reset = 1'b1;
        X = 32'h8DDB7DD3;
        R = 32'h050D6C7F;
        tick();
        check("load_y", Y, 32'd0);
        check("load_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        run_expect("mixA", exp_a);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("mixA_hold_y", Y, exp_a);
            check("mixA_hold_done", {31'd0, done}, 32'd1);
        end

        // reset while DONE clears Y on the same edge
        reset = 1'b1;
        tick();
        check("rst_in_done_y", Y, 32'd0);
        check("rst_in_done_done", {31'd0, done}, 32'd0);

        // operand changes after load have no effect
        reset = 1'b0;
        X = 32'hFFFFFFFF;
        R = 32'hFFFFFFFF;
        run_expect("mixA_xr_change", exp_a);

        // abort mid-run: 9 rounds, reload on the 10th edge with new operands
        reset = 1'b1;
        X = 32'h12345678;
        R = 32'h9ABCDEF0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("abort_pre_done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        X = 32'h8DDB7DD3;
        R = 32'h050D6C7F;
        tick();
        check("abort_y", Y, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        run_expect("abort_rerun", exp_a);

        // uninterrupted run of the second operand set
        reset = 1'b1;
        X = 32'h12345678;
        R = 32'h9ABCDEF0;
        tick();
        reset = 1'b0;
        run_expect("mixB", exp_b);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
